clk_en_sequencer: RTL and testbench

//  Sequences the per-domain enable vector of the clock generator. Bits turn on one at a time,

---
 rtl/clk_seq_pkg.sv | 19 +
 rtl/clk_seq_pick.sv | 35 +++
 rtl/clk_en_sequencer.sv | 151 +++++++++++++++
 tb/tb_clk_en_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_seq_pkg.sv
// -----------------------------------------------------------------------------
// clk_seq_pkg
// Shared definitions for the clock-enable sequencer.
//   N_CLK_DEF        default number of clock domains
//   GAP_DEF          default settle gap (idle cycles between clk_en bit changes)
//   clk_seq_state_t  sequencer FSM state encoding
// -----------------------------------------------------------------------------
package clk_seq_pkg;

    localparam int N_CLK_DEF = 13;
    localparam int GAP_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2
    } clk_seq_state_t;

endpackage

// File: rtl/clk_seq_pick.sv
// -----------------------------------------------------------------------------
// clk_seq_pick
// Combinational bit picker: reports the lowest and highest set bit of v.
// Ports:
//   v       in   N    vector to scan
//   lo_idx  out  IW   index of the lowest set bit (0 when v == 0)
//   hi_idx  out  IW   index of the highest set bit (0 when v == 0)
//   any     out  1    at least one bit of v is set
// -----------------------------------------------------------------------------
module clk_seq_pick #(
    parameter  int N  = 13,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  v,
    output logic [IW-1:0] lo_idx,
    output logic [IW-1:0] hi_idx,
    output logic          any
);

    // Scan downward for lo and upward for hi: the last hit written wins,
    // which is the lowest (resp. highest) set bit.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lo_idx = IW'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (v[i]) hi_idx = IW'(i);
        end
    end

    assign any = |v;

endmodule

// File: rtl/clk_en_sequencer.sv
// -----------------------------------------------------------------------------
// clk_en_sequencer
// Sequences the per-domain clock enable vector: bits turn on one at a time,
// lowest index first, then turn off one at a time, highest index first.
// Successive bit changes are separated by GAP_CYCLES idle cycles.
//
// Parameters:
//   N_CLK       number of clock domains
//   GAP_CYCLES  idle cycles between successive clk_en changes (>= 1)
//
// Ports:
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   bypass     in   1      only when CLK_EN_SEQ_BYPASS_EN is defined:
//                          clk_en follows req_en directly while high
//   req_en     in   N_CLK  requested enable mask (level)
//   clk_en     out  N_CLK  sequenced enable mask (registered)
//   busy       out  1      a sequence is in progress
//   done       out  1      one-cycle pulse when clk_en reaches the target
//   dbg_state  out  2      current FSM state, for observation only
//
// Build option: define CLK_EN_SEQ_BYPASS_EN to add the bypass input.
//
// Interface protocol: req_en is a level, not a valid/ready handshake. The
// sequencer samples it only in IDLE; once a sequence starts the target is
// frozen until done pulses, and any req_en change made meanwhile is picked
// up in IDLE on the cycle after done.
// -----------------------------------------------------------------------------
module clk_en_sequencer
    import clk_seq_pkg::*;
#(
    parameter int N_CLK      = N_CLK_DEF,
    parameter int GAP_CYCLES = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CLK_EN_SEQ_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic [N_CLK-1:0] req_en,
    output logic [N_CLK-1:0] clk_en,
    output logic             busy,
    output logic             done,
    output clk_seq_state_t   dbg_state
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);
    localparam int IW    = (N_CLK > 1) ? $clog2(N_CLK) : 1;
    localparam logic [N_CLK-1:0] LSB_ONE = N_CLK'(1);

    clk_seq_state_t   r_state;
    logic [N_CLK-1:0] r_target;
    logic [N_CLK-1:0] r_clk_en;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [N_CLK-1:0] w_en_vec;
    logic [N_CLK-1:0] w_dis_vec;
    logic [IW-1:0]    w_en_lo;
    logic [IW-1:0]    w_en_hi_unused;
    logic [IW-1:0]    w_dis_lo_unused;
    logic [IW-1:0]    w_dis_hi;
    logic             w_en_any;
    logic             w_dis_any;
    logic [N_CLK-1:0] w_set_mask;
    logic [N_CLK-1:0] w_clr_mask;

    // Bits still to turn on, and bits still to turn off.
    assign w_en_vec  = r_target & ~r_clk_en;
    assign w_dis_vec = ~r_target & r_clk_en;

    clk_seq_pick #(.N(N_CLK)) u_pick_en (
        .v      (w_en_vec),
        .lo_idx (w_en_lo),
        .hi_idx (w_en_hi_unused),
        .any    (w_en_any)
    );

    clk_seq_pick #(.N(N_CLK)) u_pick_dis (
        .v      (w_dis_vec),
        .lo_idx (w_dis_lo_unused),
        .hi_idx (w_dis_hi),
        .any    (w_dis_any)
    );

    assign w_set_mask = LSB_ONE << w_en_lo;
    assign w_clr_mask = LSB_ONE << w_dis_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_clk_en <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
`ifdef CLK_EN_SEQ_BYPASS_EN
            if (bypass) begin
                // Direct pass-through; sequencing restarts from whatever
                // clk_en holds when bypass drops.
                r_clk_en <= req_en;
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_cnt    <= '0;
            end else
`endif
            begin
                case (r_state)
                    IDLE: begin
                        if (req_en != r_clk_en) begin
                            r_target <= req_en;
                            r_busy   <= 1'b1;
                            r_state  <= STEP;
                        end
                    end
                    STEP: begin
                        // All enables are issued before any disable.
                        if (w_en_any) begin
                            r_clk_en <= r_clk_en | w_set_mask;
                            r_cnt    <= CNT_W'(GAP_CYCLES);
                            r_state  <= WAIT;
                        end else if (w_dis_any) begin
                            r_clk_en <= r_clk_en & ~w_clr_mask;
                            r_cnt    <= CNT_W'(GAP_CYCLES);
                            r_state  <= WAIT;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    WAIT: begin
                        // Leaving on cnt==1 spaces changes GAP_CYCLES+1 edges apart.
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) r_state <= STEP;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign clk_en    = r_clk_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_clk_en_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_en_sequencer
// Self-checking bench for clk_en_sequencer (N_CLK=13, GAP_CYCLES=4).
// Each vector drives req_en, advances a number of clock edges and compares
// clk_en/busy/done after the last edge; done must stay low on the edges in
// between. Hand-written sequences cover async reset, no-op hold and bypass
// (bypass only when CLK_EN_SEQ_BYPASS_EN is defined).
// -----------------------------------------------------------------------------
module tb_clk_en_sequencer;
    import clk_seq_pkg::*;

    localparam int N = 13;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_en;
    logic [N-1:0]   clk_en;
    logic           busy;
    logic           done;
    clk_seq_state_t dbg_state;
`ifdef CLK_EN_SEQ_BYPASS_EN
    logic           bypass;
`endif

    clk_en_sequencer #(.N_CLK(N), .GAP_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CLK_EN_SEQ_BYPASS_EN
        .bypass    (bypass),
`endif
        .req_en    (req_en),
        .clk_en    (clk_en),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string        name;
        logic [N-1:0] req;
        int           cyc;
        logic [N-1:0] exp_en;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic [N-1:0] req, int cyc,
                                logic [N-1:0] exp_en, logic exp_busy, logic exp_done);
        vec_t v;
        v.name     = name;
        v.req      = req;
        v.cyc      = cyc;
        v.exp_en   = exp_en;
        v.exp_busy = exp_busy;
        v.exp_done = exp_done;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [N-1:0] exp_en, logic exp_busy, logic exp_done);
        n_vec++;
        if (clk_en !== exp_en || busy !== exp_busy || done !== exp_done) begin
            n_err++;
            $display("FAIL %s: got clk_en=%h busy=%b done=%b, want clk_en=%h busy=%b done=%b",
                     name, clk_en, busy, done, exp_en, exp_busy, exp_done);
        end
    endtask

    task automatic check_done_low(string name);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: early done, got done=%b want 0 (clk_en=%h)", name, done, clk_en);
        end
    endtask

    task automatic run_vec(vec_t v);
        req_en = v.req;
        for (int c = 1; c <= v.cyc; c++) begin
            tick();
            if (c < v.cyc) check_done_low(v.name);
        end
        check(v.name, v.exp_en, v.exp_busy, v.exp_done);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n  = 1'b1;
        req_en = '0;
`ifdef CLK_EN_SEQ_BYPASS_EN
        bypass = 1'b0;
`endif
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset", 13'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", 13'h0000, 1'b0, 1'b0);

        // ---------------- vector table ----------------
        // Enable ordering 0 -> 0x0005: changes at edges 2 and 7, done at 12.
        tbl.push_back(mk("en_e1",    13'h0005, 1, 13'h0000, 1, 0));
        tbl.push_back(mk("en_e2",    13'h0005, 1, 13'h0001, 1, 0));
        tbl.push_back(mk("en_e6",    13'h0005, 4, 13'h0001, 1, 0));
        tbl.push_back(mk("en_e7",    13'h0005, 1, 13'h0005, 1, 0));
        tbl.push_back(mk("en_e11",   13'h0005, 4, 13'h0005, 1, 0));
        tbl.push_back(mk("en_done",  13'h0005, 1, 13'h0005, 0, 1));
        tbl.push_back(mk("en_idle",  13'h0005, 1, 13'h0005, 0, 0));
        // Mixed 0x0005 -> 0x1002: set b1, set b12, clear b2, clear b0.
        tbl.push_back(mk("mix_e1",   13'h1002, 1, 13'h0005, 1, 0));
        tbl.push_back(mk("mix_b1",   13'h1002, 1, 13'h0007, 1, 0));
        tbl.push_back(mk("mix_b12",  13'h1002, 5, 13'h1007, 1, 0));
        tbl.push_back(mk("mix_c2",   13'h1002, 5, 13'h1003, 1, 0));
        tbl.push_back(mk("mix_c0",   13'h1002, 5, 13'h1002, 1, 0));
        tbl.push_back(mk("mix_e21",  13'h1002, 4, 13'h1002, 1, 0));
        tbl.push_back(mk("mix_done", 13'h1002, 1, 13'h1002, 0, 1));
        tbl.push_back(mk("mix_idle", 13'h1002, 1, 13'h1002, 0, 0));
        // 0x1002 -> 0x1FFF: 11 bits to set, done at edge 2+11*5 = 57.
        tbl.push_back(mk("all_on",   13'h1FFF, 57, 13'h1FFF, 0, 1));

        foreach (tbl[i]) run_vec(tbl[i]);

        // ---------------- no-op hold ----------------
        for (int c = 0; c < 20; c++) begin
            tick();
            check("noop", 13'h1FFF, 1'b0, 1'b0);
        end

        // ---------------- back to zero, then mid-sequence change ----------------
        tbl.delete();
        // 13 bits to clear: done at edge 2+13*5 = 67.
        tbl.push_back(mk("all_off",  13'h0000, 67, 13'h0000, 0, 1));
        tbl.push_back(mk("mid_e1",   13'h0005, 1, 13'h0000, 1, 0));
        tbl.push_back(mk("mid_e2",   13'h0005, 1, 13'h0001, 1, 0));
        tbl.push_back(mk("mid_e3",   13'h0005, 1, 13'h0001, 1, 0));
        // req_en drops after edge 3 but the frozen target still completes.
        tbl.push_back(mk("mid_e7",   13'h0000, 4, 13'h0005, 1, 0));
        tbl.push_back(mk("mid_done", 13'h0000, 5, 13'h0005, 0, 1));
        tbl.push_back(mk("mid_rest", 13'h0000, 1, 13'h0005, 1, 0));
        tbl.push_back(mk("mid_c2",   13'h0000, 1, 13'h0001, 1, 0));
        tbl.push_back(mk("mid_c0",   13'h0000, 5, 13'h0000, 1, 0));
        tbl.push_back(mk("mid_done2",13'h0000, 5, 13'h0000, 0, 1));
        // Reach mid-WAIT with clk_en=0x0003 for the async reset check.
        tbl.push_back(mk("rst_e1",   13'h0003, 1, 13'h0000, 1, 0));
        tbl.push_back(mk("rst_e2",   13'h0003, 1, 13'h0001, 1, 0));
        tbl.push_back(mk("rst_e7",   13'h0003, 5, 13'h0003, 1, 0));
        tbl.push_back(mk("rst_e8",   13'h0003, 1, 13'h0003, 1, 0));

        foreach (tbl[i]) run_vec(tbl[i]);

        // ---------------- async reset mid-WAIT ----------------
        n_vec++;
        if (dbg_state !== WAIT) begin
            n_err++;
            $display("FAIL pre_rst_state: got %0d want %0d", dbg_state, WAIT);
        end
        rst_n = 1'b0;
        #2;
        check("async_rst", 13'h0000, 1'b0, 1'b0);
        n_vec++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL async_rst_state: got %0d want %0d", dbg_state, IDLE);
        end
        req_en = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_release", 13'h0000, 1'b0, 1'b0);

`ifdef CLK_EN_SEQ_BYPASS_EN
        // ---------------- bypass ----------------
        bypass = 1'b1;
        req_en = 13'h0AAA;
        tick();
        check("byp_on", 13'h0AAA, 1'b0, 1'b0);
        tick();
        check("byp_hold", 13'h0AAA, 1'b0, 1'b0);
        bypass = 1'b0;
        tbl.delete();
        tbl.push_back(mk("byp_e1",   13'h0000, 1, 13'h0AAA, 1, 0));
        tbl.push_back(mk("byp_c11",  13'h0000, 1, 13'h02AA, 1, 0));
        tbl.push_back(mk("byp_c9",   13'h0000, 5, 13'h00AA, 1, 0));
        tbl.push_back(mk("byp_c7",   13'h0000, 5, 13'h002A, 1, 0));
        tbl.push_back(mk("byp_c5",   13'h0000, 5, 13'h000A, 1, 0));
        tbl.push_back(mk("byp_c3",   13'h0000, 5, 13'h0002, 1, 0));
        tbl.push_back(mk("byp_c1",   13'h0000, 5, 13'h0000, 1, 0));
        tbl.push_back(mk("byp_done", 13'h0000, 5, 13'h0000, 0, 1));
        foreach (tbl[i]) run_vec(tbl[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
